data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the core's load/store data interface: accepts the request issued for decoded load/store instructions (req, we, type, sign-extend), performs the access on an internal word-organised RAM, and returns a response after a fixed number of wait states.
- Sits between the load/store unit and on-chip data RAM.
- Serves as the data memory in core-level simulation and FPGA builds.

Parameters:
- DATA_WIDTH, 32, data bus width; only 32 supported.
- DEPTH_WORDS, 1024, RAM depth in 32-bit words; must be a power of two.
- WAIT_CYCLES, 1, extra cycles between grant and response; 0..15.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- data_req_i  in  1  access request.
- data_gnt_o  out  1  request accepted this cycle.
- data_addr_i  in  32  byte address.
- data_we_i  in  1  1 = store, 0 = load.
- data_type_i  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- data_sign_ext_i  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- data_wdata_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- data_rvalid_o  out  1  one-cycle response strobe, for both loads and stores.
- data_rdata_o  out  32  load result, extended; 0 for stores and errors.
- data_err_o  out  1  access error, valid with data_rvalid_o.

Interface: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset state: IDLE.
  - data_gnt_o = 0, data_rvalid_o = 0, data_rdata_o = 0, data_err_o = 0.
  - Wait counter = 0; captured request registers = 0.
  - RAM contents are not reset.
- State machine: IDLE -> WAIT -> RESP -> IDLE.
- IDLE:
  - data_gnt_o = data_req_i (combinational, IDLE only).
  - On req: capture addr, we, type, sign_ext, wdata.
  - Load counter with WAIT_CYCLES. Go to WAIT, or straight to RESP if WAIT_CYCLES = 0.
- WAIT:
  - data_gnt_o = 0. Counter decrements each cycle.
  - When counter = 1 (this is the WAIT_CYCLES-th WAIT cycle), go to RESP.
- RESP:
  - Registered outputs data_rvalid_o / data_rdata_o / data_err_o are high/valid for exactly this one cycle.
  - Store commit to RAM happens on the clock edge entering RESP. A load issued immediately after sees the new data.
  - data_gnt_o = 0 in RESP. Next state is always IDLE.
  - data_req_i held high is granted again in the following IDLE cycle.
- Latency: grant cycle T, response cycle T + 1 + WAIT_CYCLES. Maximum throughput: one access per WAIT_CYCLES + 2 cycles.
- Requester must hold all inputs stable while data_req_i = 1 and data_gnt_o = 0. Inputs are ignored outside the IDLE grant cycle.
- Word index = addr[log2(DEPTH_WORDS)+1 : 2]. Byte offset = addr[1:0].
- Load path:
  - Read word, shift right by 8 × offset.
  - Byte: bits [7:0], extended from bit 7 per sign_ext.
  - Half: bits [15:0], extended from bit 15.
  - Word: unchanged; sign_ext is ignored.
- Store path:
  - Byte enables: byte = 1 lane at offset; half = lanes offset, offset+1; word = all 4 lanes.
  - Data is shifted left by 8 × offset before writing. Unselected lanes are unchanged.
- Error conditions (with DMEM_ERR_EN):
  - type = 11.
  - half with addr[0] = 1.
  - word with addr[1:0] != 0.
  - addr >= 4 × DEPTH_WORDS.
  - On error: no RAM write, data_rdata_o = 0, data_err_o = 1 with data_rvalid_o.
- Address wrap: without error detection, upper address bits are ignored (modulo DEPTH_WORDS).
- Reset mid-operation (WAIT or RESP): return to IDLE immediately.
  - The pending store is dropped if reset arrives before the RESP-entry edge.
  - No response is issued for the aborted access.
- Simultaneous req and rst: reset wins, no grant.

Optional Feature:
- Macro: DMEM_ERR_EN.
- Defined: error detection as above.
- Undefined:
  - data_err_o is tied to 0.
  - Misaligned halfword/word accesses are forced aligned (addr[0], or addr[1:0], treated as 0).
  - type 11 is treated as word.
  - Out-of-range addresses wrap.

Test Plan:
- WAIT_CYCLES = 1: store word 0xDEADBEEF to 0x10, then load word 0x10 -> grant at T, rvalid at T+2, rdata = 0xDEADBEEF, err = 0.
- Store byte 0x80 to 0x13, then load byte 0x13:
  - sign_ext = 1 -> 0xFFFFFF80; sign_ext = 0 -> 0x00000080.
  - Word 0x10 reads 0x80ADBEEF.
- Store half 0x1234 to 0x22, then load word 0x20 -> 0x1234xxxx with the lower half unchanged. Load half 0x22, sign_ext = 1 -> 0x00001234.
- DMEM_ERR_EN defined:
  - Load word 0x11 -> rvalid = 1, err = 1, rdata = 0.
  - Store word to 0x1000 (DEPTH_WORDS = 1024) -> err = 1, and RAM word 0 is unchanged.
- Back-to-back: req held high for two loads, WAIT_CYCLES = 0 -> grants 2 cycles apart, rvalid one cycle after each grant, no grant in RESP.
- Assert rst during WAIT of a store with WAIT_CYCLES = 3 -> rvalid never asserts, and a subsequent load shows the old data.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-organised data RAM answering load/store requests after WAIT_CYCLES wait states.
// Define DMEM_ERR_EN to flag illegal, misaligned and out-of-range accesses.
module data_mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  input  logic [31:0]           data_addr_i,
  input  logic                  data_we_i,
  input  logic [1:0]            data_type_i,
  input  logic                  data_sign_ext_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  data_err_o
);
  // state  | meaning
  // S_IDLE | ready; grants a pending request combinationally
  // S_WAIT | counting wait states for the captured access
  // S_RESP | one-cycle response strobe; store already committed

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        capture, enter_resp;

  logic [31:0] addr_q, wdata_q;
  logic        we_q, sext_q;
  logic [1:0]  type_q;

  logic [31:0] acc_addr, acc_wdata;
  logic        acc_we, acc_sext, acc_err;
  logic [1:0]  acc_type, eff_type, offset;
  logic [AW-1:0] widx;

  logic [31:0] rd_word, rd_shift, load_val, wd_shift;
  logic [3:0]  be;

  logic [31:0] ram [DEPTH_WORDS];

  assign data_gnt_o = (state == S_IDLE) & data_req_i & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    capture    = 1'b0;
    enter_resp = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (data_gnt_o) begin
          capture = 1'b1;
          cnt_nxt = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_nxt  = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt  = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      type_q  <= 2'b00;
      sext_q  <= 1'b0;
      wdata_q <= '0;
    end else if (capture) begin
      addr_q  <= data_addr_i;
      we_q    <= data_we_i;
      type_q  <= data_type_i;
      sext_q  <= data_sign_ext_i;
      wdata_q <= data_wdata_i;
    end
  end

  // With zero wait states the access completes on the grant edge, before capture.
  always_comb begin
    if (state == S_IDLE) begin
      acc_addr  = data_addr_i;
      acc_we    = data_we_i;
      acc_type  = data_type_i;
      acc_sext  = data_sign_ext_i;
      acc_wdata = data_wdata_i;
    end else begin
      acc_addr  = addr_q;
      acc_we    = we_q;
      acc_type  = type_q;
      acc_sext  = sext_q;
      acc_wdata = wdata_q;
    end
  end

  assign widx = acc_addr[AW+1:2];

`ifdef DMEM_ERR_EN
  always_comb begin
    offset   = acc_addr[1:0];
    eff_type = acc_type;
    acc_err  = (acc_type == 2'b11) ||
               (acc_type == 2'b01 && acc_addr[0]) ||
               (acc_type == 2'b10 && acc_addr[1:0] != 2'b00) ||
               (acc_addr[31:AW+2] != '0);
  end
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^acc_addr[31:AW+2];

  always_comb begin
    offset   = acc_addr[1:0];
    eff_type = acc_type;
    acc_err  = 1'b0;
    if (acc_type == 2'b11) eff_type = 2'b10;
    if (eff_type == 2'b01) offset[0] = 1'b0;
    if (eff_type == 2'b10) offset = 2'b00;
  end
`endif

  always_comb begin
    rd_word  = ram[widx];
    rd_shift = rd_word >> {offset, 3'b000};
    wd_shift = acc_wdata << {offset, 3'b000};
    case (eff_type)
      2'b00: begin
        load_val = {{24{acc_sext & rd_shift[7]}}, rd_shift[7:0]};
        be       = 4'b0001 << offset;
      end
      2'b01: begin
        load_val = {{16{acc_sext & rd_shift[15]}}, rd_shift[15:0]};
        be       = 4'b0011 << offset;
      end
      default: begin
        load_val = rd_shift;
        be       = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (enter_resp && acc_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ram[widx][8*i +: 8] <= wd_shift[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_rvalid_o <= 1'b0;
      data_rdata_o  <= '0;
      data_err_o    <= 1'b0;
    end else begin
      data_rvalid_o <= enter_resp;
      data_err_o    <= enter_resp & acc_err;
      data_rdata_o  <= (enter_resp && !acc_we && !acc_err) ? load_val : '0;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised and directed checks of data_mem_responder at 0, 1 and 3 wait states
// against a byte-array model of the memory.
module tb_data_mem_responder;
  localparam int DEPTH = 1024;
  localparam int NB    = 4 * DEPTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst, req, gnt, we, sx, rv, er;
  logic [1:0]  typ [3];
  logic [31:0] addr [3];
  logic [31:0] wd [3];
  logic [31:0] rd [3];

  logic [7:0] mem_m [3][NB];
  int n_checks = 0;
  int n_fail   = 0;

  data_mem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .data_req_i(req[0]), .data_gnt_o(gnt[0]),
    .data_addr_i(addr[0]), .data_we_i(we[0]), .data_type_i(typ[0]),
    .data_sign_ext_i(sx[0]), .data_wdata_i(wd[0]), .data_rvalid_o(rv[0]),
    .data_rdata_o(rd[0]), .data_err_o(er[0]));

  data_mem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .data_req_i(req[1]), .data_gnt_o(gnt[1]),
    .data_addr_i(addr[1]), .data_we_i(we[1]), .data_type_i(typ[1]),
    .data_sign_ext_i(sx[1]), .data_wdata_i(wd[1]), .data_rvalid_o(rv[1]),
    .data_rdata_o(rd[1]), .data_err_o(er[1]));

  data_mem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) u_dut2 (
    .clk(clk), .rst(rst[2]), .data_req_i(req[2]), .data_gnt_o(gnt[2]),
    .data_addr_i(addr[2]), .data_we_i(we[2]), .data_type_i(typ[2]),
    .data_sign_ext_i(sx[2]), .data_wdata_i(wd[2]), .data_rvalid_o(rv[2]),
    .data_rdata_o(rd[2]), .data_err_o(er[2]));

  function automatic int wc(input int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : 3;
  endfunction

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endfunction

  // Byte-level reference: size from type, then either an error, or a wrapped/aligned access.
  function automatic void model_access(input int k, input logic [31:0] a, input logic w,
                                       input logic [1:0] t, input logic s, input logic [31:0] d,
                                       output logic [31:0] r, output logic e);
    int unsigned n, base;
    logic [31:0] v;
    r = '0;
    e = 1'b0;
    n = (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : 4;
`ifdef DMEM_ERR_EN
    e = (t == 2'd3) || (a % n != 0) || (a >= 32'(NB));
    if (e) return;
    base = a;
`else
    base = a % NB;
    base = base - base % n;
`endif
    if (w) begin
      for (int i = 0; i < 4; i++) if (i < n) mem_m[k][base+i] = d[8*i +: 8];
      return;
    end
    v = '0;
    for (int i = 0; i < 4; i++) if (i < n) v[8*i +: 8] = mem_m[k][base+i];
    if (s && n < 4 && v[8*n-1]) begin
      for (int i = 0; i < 32; i++) if (i >= 8*n) v[i] = 1'b1;
    end
    r = v;
  endfunction

  task automatic access(input int k, input logic [31:0] a, input logic w, input logic [1:0] t,
                        input logic s, input logic [31:0] d,
                        output logic [31:0] obs, output logic obs_err);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          c;
    model_access(k, a, w, t, s, d, exp_rd, exp_err);
    @(negedge clk);
    req[k] = 1'b1; addr[k] = a; we[k] = w; typ[k] = t; sx[k] = s; wd[k] = d;
    #1;
    c = 0;
    while (!gnt[k] && c < 20) begin
      @(negedge clk); #1; c++;
    end
    chk("grant", 32'(gnt[k]), 32'd1);
    c = 0;
    do begin
      @(negedge clk);
      req[k] = 1'b0;
      c++;
    end while (!rv[k] && c < 20);
    chk("latency", 32'(c), 32'(wc(k) + 1));
    chk("rdata", rd[k], exp_rd);
    chk("err", 32'(er[k]), 32'(exp_err));
    obs     = rd[k];
    obs_err = er[k];
  endtask

  initial begin
    logic [31:0] o, a, old_x;
    logic        e, seen;
    logic [1:0]  t;

    rst = 3'b111; req = 3'b111; we = '0; sx = '0;
    for (int k = 0; k < 3; k++) begin
      addr[k] = '0; typ[k] = 2'b10; wd[k] = '0;
    end
    #1;
    for (int k = 0; k < 3; k++) chk("rst_req_gnt", 32'(gnt[k]), 32'd0);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_gnt", 32'(gnt[k]), 32'd0);
      chk("rst_rvalid", 32'(rv[k]), 32'd0);
      chk("rst_rdata", rd[k], 32'd0);
      chk("rst_err", 32'(er[k]), 32'd0);
    end
    req = '0;
    rst = '0;

    for (int i = 0; i < 64; i++) access(1, 32'(4*i), 1'b1, 2'b10, 1'b0, $urandom, o, e);

    access(1, 32'h10, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF, o, e);
    access(1, 32'h10, 1'b0, 2'b10, 1'b0, 32'h0, o, e);
    chk("plan_word", o, 32'hDEADBEEF);
    chk("plan_word_err", 32'(e), 32'd0);
    access(1, 32'h13, 1'b1, 2'b00, 1'b0, 32'h80, o, e);
    access(1, 32'h13, 1'b0, 2'b00, 1'b1, 32'h0, o, e);
    chk("plan_byte_sx", o, 32'hFFFFFF80);
    access(1, 32'h13, 1'b0, 2'b00, 1'b0, 32'h0, o, e);
    chk("plan_byte_zx", o, 32'h00000080);
    access(1, 32'h10, 1'b0, 2'b10, 1'b0, 32'h0, o, e);
    chk("plan_byte_word", o, 32'h80ADBEEF);
    access(1, 32'h22, 1'b1, 2'b01, 1'b0, 32'h1234, o, e);
    access(1, 32'h20, 1'b0, 2'b10, 1'b0, 32'h0, o, e);
    chk("plan_half_word_hi", {16'h0, o[31:16]}, 32'h1234);
    access(1, 32'h22, 1'b0, 2'b01, 1'b1, 32'h0, o, e);
    chk("plan_half_sx", o, 32'h00001234);
`ifdef DMEM_ERR_EN
    access(1, 32'h11, 1'b0, 2'b10, 1'b0, 32'h0, o, e);
    chk("plan_misalign_err", 32'(e), 32'd1);
    chk("plan_misalign_rdata", o, 32'h0);
    access(1, 32'h0, 1'b0, 2'b10, 1'b0, 32'h0, old_x, e);
    access(1, 32'h1000, 1'b1, 2'b10, 1'b0, 32'hCAFEF00D, o, e);
    chk("plan_range_err", 32'(e), 32'd1);
    access(1, 32'h0, 1'b0, 2'b10, 1'b0, 32'h0, o, e);
    chk("plan_range_word0", o, old_x);
`endif

    for (int i = 0; i < 150; i++) begin
      a = {20'h0, 6'($urandom_range(0, 63)), 4'h0} >> 2;
      a = a | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 1048575)) << 12);
      t = 2'($urandom_range(0, 3));
      access(1, a, 1'($urandom_range(0, 1)), t, 1'($urandom_range(0, 1)), $urandom, o, e);
    end

    access(0, 32'h40, 1'b1, 2'b10, 1'b0, 32'hA5A55A5A, o, e);
    @(negedge clk);
    req[0] = 1'b1; addr[0] = 32'h40; we[0] = 1'b0; typ[0] = 2'b10; sx[0] = 1'b0;
    #1;
    chk("b2b_gnt1", 32'(gnt[0]), 32'd1);
    @(negedge clk); #1;
    chk("b2b_rv1", 32'(rv[0]), 32'd1);
    chk("b2b_rd1", rd[0], 32'hA5A55A5A);
    chk("b2b_no_gnt_resp", 32'(gnt[0]), 32'd0);
    @(negedge clk); #1;
    chk("b2b_gnt2", 32'(gnt[0]), 32'd1);
    chk("b2b_rv_idle", 32'(rv[0]), 32'd0);
    @(negedge clk);
    req[0] = 1'b0;
    #1;
    chk("b2b_rv2", 32'(rv[0]), 32'd1);
    chk("b2b_rd2", rd[0], 32'hA5A55A5A);

    access(2, 32'h80, 1'b1, 2'b10, 1'b0, 32'h13579BDF, o, e);
    @(negedge clk);
    req[2] = 1'b1; addr[2] = 32'h80; we[2] = 1'b1; typ[2] = 2'b10; wd[2] = 32'hFFFF0000;
    #1;
    chk("abort_gnt", 32'(gnt[2]), 32'd1);
    @(negedge clk);
    req[2] = 1'b0;
    @(negedge clk);
    rst[2] = 1'b1;
    #1;
    chk("abort_rv_in_rst", 32'(rv[2]), 32'd0);
    @(negedge clk);
    rst[2] = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rv[2]) seen = 1'b1;
    end
    chk("abort_no_rvalid", 32'(seen), 32'd0);
    access(2, 32'h80, 1'b0, 2'b10, 1'b0, 32'h0, o, e);
    chk("abort_old_data", o, 32'h13579BDF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
